// File: rtl/wt_l15_rtrn_decoder.sv
// L1.5 return-packet decoder: buffers incoming return packets and fans them out
// to the icache/dcache return channels, tracking per-destination delivery.
module wt_l15_rtrn_decoder #(
  parameter int unsigned RTRN_FIFO_DEPTH = 2,
  parameter int unsigned TID_WIDTH       = 2,
  parameter bit          SWAP_ENDIAN     = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 l15_val_i,
  output logic                 l15_header_ack_o,
  input  logic [3:0]           l15_returntype_i,
  input  logic [TID_WIDTH-1:0] l15_threadid_i,
  input  logic [255:0]         l15_data_i,
  input  logic                 l15_inval_icache_i,
  input  logic                 l15_inval_dcache_i,
  input  logic [11:0]          l15_inval_addr_i,
  input  logic [1:0]           l15_inval_way_i,
  output logic                 icache_rtrn_vld_o,
  input  logic                 icache_rtrn_rdy_i,
  output logic                 icache_rtrn_type_o,
  output logic [255:0]         icache_rtrn_data_o,
  output logic                 dcache_rtrn_vld_o,
  input  logic                 dcache_rtrn_rdy_i,
  output logic [2:0]           dcache_rtrn_type_o,
  output logic [127:0]         dcache_rtrn_data_o,
  output logic [TID_WIDTH-1:0] rtrn_tid_o,
  output logic [11:0]          rtrn_inval_addr_o,
  output logic [1:0]           rtrn_inval_way_o,
  output logic [7:0]           err_cnt_o
);

  localparam int unsigned PTR_W = $clog2(RTRN_FIFO_DEPTH);

  typedef enum logic [3:0] {
    L15_LOAD_RET   = 4'b0000,
    L15_IFILL_RET  = 4'b0001,
    L15_EVICT_REQ  = 4'b0011,
    L15_ST_ACK     = 4'b0100,
    L15_INT_RET    = 4'b0111,
    L15_ATOMIC_RES = 4'b1110
  } l15_rtrn_e;

  typedef enum logic {
    IC_INV_REQ   = 1'b0,
    IC_IFILL_ACK = 1'b1
  } ic_rtrn_e;

  typedef enum logic [2:0] {
    DC_INV_REQ    = 3'd0,
    DC_STORE_ACK  = 3'd1,
    DC_LOAD_ACK   = 3'd2,
    DC_ATOMIC_ACK = 3'd3,
    DC_INT_ACK    = 3'd4
  } dc_rtrn_e;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  typedef struct packed {
    logic [3:0]           rtype;
    logic [TID_WIDTH-1:0] tid;
    logic [255:0]         data;
    logic                 inv_i;
    logic                 inv_d;
    logic [11:0]          addr;
    logic [1:0]           way;
  } pkt_t;

  function automatic logic [63:0] swap64(input logic [63:0] w);
    logic [63:0] r;
    r = w;
    if (SWAP_ENDIAN) begin
      for (int unsigned b = 0; b < 8; b++) begin
        r[8*b +: 8] = w[8*(7-b) +: 8];
      end
    end
    return r;
  endfunction

  pkt_t             mem_q [RTRN_FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             ic_done_q, ic_done_d, dc_done_q, dc_done_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  state_e           state_q, state_d;

  pkt_t     head;
  logic     need_i, need_d, unsup;
  ic_rtrn_e ic_type;
  dc_rtrn_e dc_type;
  logic     sending, push, pop, hs_i, hs_d;

  // Destination and channel type for the packet currently at the FIFO head.
  always_comb begin
    head    = mem_q[rptr_q];
    need_i  = 1'b0;
    need_d  = 1'b0;
    unsup   = 1'b0;
    ic_type = IC_INV_REQ;
    dc_type = DC_INV_REQ;
    case (head.rtype)
      L15_LOAD_RET:   begin need_d = 1'b1; dc_type = DC_LOAD_ACK;   end
      L15_ATOMIC_RES: begin need_d = 1'b1; dc_type = DC_ATOMIC_ACK; end
      L15_ST_ACK:     begin need_d = 1'b1; dc_type = DC_STORE_ACK;  end
      L15_INT_RET:    begin need_d = 1'b1; dc_type = DC_INT_ACK;    end
      L15_IFILL_RET:  begin need_i = 1'b1; ic_type = IC_IFILL_ACK;  end
      L15_EVICT_REQ: begin
        need_i = head.inv_i;
        need_d = head.inv_d;
        unsup  = ~(head.inv_i | head.inv_d);
      end
      default: unsup = 1'b1;
    endcase
  end

  always_comb begin
    sending           = (state_q == SEND);
    icache_rtrn_vld_o = sending & need_i & ~ic_done_q;
    dcache_rtrn_vld_o = sending & need_d & ~dc_done_q;
    hs_i              = icache_rtrn_vld_o & icache_rtrn_rdy_i;
    hs_d              = dcache_rtrn_vld_o & dcache_rtrn_rdy_i;
    // A destination counts as delivered if it finished earlier or handshakes now.
    pop  = sending & (unsup | ((~need_i | ic_done_q | hs_i) &
                               (~need_d | dc_done_q | hs_d)));
    push = l15_val_i & ~full_q;
    l15_header_ack_o = push & rst_ni;

    icache_rtrn_type_o = sending ? ic_type : IC_INV_REQ;
    dcache_rtrn_type_o = sending ? dc_type : DC_INV_REQ;
    icache_rtrn_data_o = sending ? {swap64(head.data[192 +: 64]), swap64(head.data[128 +: 64]),
                                    swap64(head.data[64 +: 64]),  swap64(head.data[0 +: 64])}
                                 : '0;
    dcache_rtrn_data_o = sending ? {swap64(head.data[64 +: 64]), swap64(head.data[0 +: 64])} : '0;
    rtrn_tid_o         = sending ? head.tid  : '0;
    rtrn_inval_addr_o  = sending ? head.addr : '0;
    rtrn_inval_way_o   = sending ? head.way  : '0;
    err_cnt_o          = err_cnt_q;
  end

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    full_d    = full_q;
    empty_d   = empty_q;
    ic_done_d = ic_done_q;
    dc_done_d = dc_done_q;
    err_cnt_d = err_cnt_q;

    if (push) wptr_d = wptr_q + PTR_W'(1);
    if (pop)  rptr_d = rptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10: begin
        empty_d = 1'b0;
        full_d  = (wptr_d == rptr_q);
      end
      2'b01: begin
        full_d  = 1'b0;
        empty_d = (rptr_d == wptr_q);
      end
      default: ;
    endcase

    if (pop) begin
      ic_done_d = 1'b0;
      dc_done_d = 1'b0;
    end else begin
      ic_done_d = ic_done_q | hs_i;
      dc_done_d = dc_done_q | hs_d;
    end

    if (pop && unsup && (head.rtype != L15_EVICT_REQ) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end

    state_d = empty_d ? IDLE : SEND;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      ic_done_q <= 1'b0;
      dc_done_q <= 1'b0;
      err_cnt_q <= '0;
      state_q   <= IDLE;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      ic_done_q <= ic_done_d;
      dc_done_q <= dc_done_d;
      err_cnt_q <= err_cnt_d;
      state_q   <= state_d;
    end
  end

  // Payload storage needs no reset: nothing is read while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q] <= '{rtype: l15_returntype_i, tid: l15_threadid_i, data: l15_data_i,
                         inv_i: l15_inval_icache_i, inv_d: l15_inval_dcache_i,
                         addr: l15_inval_addr_i, way: l15_inval_way_i};
    end
  end

endmodule

// File: tb/tb_wt_l15_rtrn_decoder.sv
// Directed bench for wt_l15_rtrn_decoder with default parameters
// (depth 2, 2-bit TID, byte swap enabled).
module tb_wt_l15_rtrn_decoder;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         l15_val_i;
  logic         l15_header_ack_o;
  logic [3:0]   l15_returntype_i;
  logic [1:0]   l15_threadid_i;
  logic [255:0] l15_data_i;
  logic         l15_inval_icache_i;
  logic         l15_inval_dcache_i;
  logic [11:0]  l15_inval_addr_i;
  logic [1:0]   l15_inval_way_i;
  logic         icache_rtrn_vld_o;
  logic         icache_rtrn_rdy_i;
  logic         icache_rtrn_type_o;
  logic [255:0] icache_rtrn_data_o;
  logic         dcache_rtrn_vld_o;
  logic         dcache_rtrn_rdy_i;
  logic [2:0]   dcache_rtrn_type_o;
  logic [127:0] dcache_rtrn_data_o;
  logic [1:0]   rtrn_tid_o;
  logic [11:0]  rtrn_inval_addr_o;
  logic [1:0]   rtrn_inval_way_o;
  logic [7:0]   err_cnt_o;

  int pass_cnt = 0;
  int total    = 0;

  wt_l15_rtrn_decoder #(
    .RTRN_FIFO_DEPTH(2),
    .TID_WIDTH      (2),
    .SWAP_ENDIAN    (1'b1)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .l15_val_i         (l15_val_i),
    .l15_header_ack_o  (l15_header_ack_o),
    .l15_returntype_i  (l15_returntype_i),
    .l15_threadid_i    (l15_threadid_i),
    .l15_data_i        (l15_data_i),
    .l15_inval_icache_i(l15_inval_icache_i),
    .l15_inval_dcache_i(l15_inval_dcache_i),
    .l15_inval_addr_i  (l15_inval_addr_i),
    .l15_inval_way_i   (l15_inval_way_i),
    .icache_rtrn_vld_o (icache_rtrn_vld_o),
    .icache_rtrn_rdy_i (icache_rtrn_rdy_i),
    .icache_rtrn_type_o(icache_rtrn_type_o),
    .icache_rtrn_data_o(icache_rtrn_data_o),
    .dcache_rtrn_vld_o (dcache_rtrn_vld_o),
    .dcache_rtrn_rdy_i (dcache_rtrn_rdy_i),
    .dcache_rtrn_type_o(dcache_rtrn_type_o),
    .dcache_rtrn_data_o(dcache_rtrn_data_o),
    .rtrn_tid_o        (rtrn_tid_o),
    .rtrn_inval_addr_o (rtrn_inval_addr_o),
    .rtrn_inval_way_o  (rtrn_inval_way_o),
    .err_cnt_o         (err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic set_pkt(input logic [3:0] t, input logic [1:0] tid, input logic [255:0] d,
                         input logic ii, input logic id, input logic [11:0] a, input logic [1:0] w);
    l15_val_i          = 1'b1;
    l15_returntype_i   = t;
    l15_threadid_i     = tid;
    l15_data_i         = d;
    l15_inval_icache_i = ii;
    l15_inval_dcache_i = id;
    l15_inval_addr_i   = a;
    l15_inval_way_i    = w;
  endtask

  initial begin
    int acks;
    int vld_seen;
    int cyc;

    rst_ni            = 1'b0;
    icache_rtrn_rdy_i = 1'b0;
    dcache_rtrn_rdy_i = 1'b0;
    set_pkt(4'b0000, 2'd1, '0, 1'b0, 1'b0, 12'h0, 2'd0);
    #12;
    // reset state, with a valid packet offered
    chk1("rst_ack", l15_header_ack_o, 1'b0);
    chk1("rst_ic_vld", icache_rtrn_vld_o, 1'b0);
    chk1("rst_dc_vld", dcache_rtrn_vld_o, 1'b0);
    chk("rst_err", 256'(err_cnt_o), 256'(0));
    chk("rst_dc_data", 256'(dcache_rtrn_data_o), 256'(0));
    tick();
    rst_ni    = 1'b1;
    l15_val_i = 1'b0;
    tick();
    chk1("post_rst_dc_vld", dcache_rtrn_vld_o, 1'b0);

    // LOAD_RET tid 1 -> dcache LOAD_ACK, byte-swapped words
    icache_rtrn_rdy_i = 1'b1;
    dcache_rtrn_rdy_i = 1'b1;
    set_pkt(4'b0000, 2'd1, {128'h0, 64'h8899AABBCCDDEEFF, 64'h0011223344556677},
            1'b0, 1'b0, 12'h0, 2'd0);
    #1;
    chk1("ld_ack", l15_header_ack_o, 1'b1);
    chk1("ld_vld_same_cycle", dcache_rtrn_vld_o, 1'b0);
    tick();
    l15_val_i = 1'b0;
    #1;
    chk1("ld_dc_vld", dcache_rtrn_vld_o, 1'b1);
    chk1("ld_ic_vld", icache_rtrn_vld_o, 1'b0);
    chk("ld_type", 256'(dcache_rtrn_type_o), 256'(2));
    chk("ld_w0", 256'(dcache_rtrn_data_o[63:0]), 256'(64'h7766554433221100));
    chk("ld_w1", 256'(dcache_rtrn_data_o[127:64]), 256'(64'hFFEEDDCCBBAA9988));
    chk("ld_tid", 256'(rtrn_tid_o), 256'(1));
    tick();
    chk1("ld_vld_after_pop", dcache_rtrn_vld_o, 1'b0);

    // IFILL_RET -> icache IFILL_ACK with upper words
    set_pkt(4'b0001, 2'd2, {64'hDEADBEEFCAFEF00D, 64'h0102030405060708, 128'h0},
            1'b0, 1'b0, 12'h0, 2'd0);
    tick();
    l15_val_i = 1'b0;
    chk1("if_ic_vld", icache_rtrn_vld_o, 1'b1);
    chk1("if_dc_vld", dcache_rtrn_vld_o, 1'b0);
    chk1("if_type", icache_rtrn_type_o, 1'b1);
    chk("if_w2", 256'(icache_rtrn_data_o[191:128]), 256'(64'h0807060504030201));
    chk("if_w3", 256'(icache_rtrn_data_o[255:192]), 256'(64'h0DF0FECAEFBEADDE));
    chk("if_tid", 256'(rtrn_tid_o), 256'(2));
    tick();
    chk1("if_vld_after_pop", icache_rtrn_vld_o, 1'b0);

    // EVICT_REQ to both caches; dcache stalls three cycles
    icache_rtrn_rdy_i = 1'b1;
    dcache_rtrn_rdy_i = 1'b0;
    set_pkt(4'b0011, 2'd3, '0, 1'b1, 1'b1, 12'hABC, 2'd2);
    tick();
    l15_val_i = 1'b0;
    chk1("ev_a_ic_vld", icache_rtrn_vld_o, 1'b1);
    chk1("ev_a_dc_vld", dcache_rtrn_vld_o, 1'b1);
    chk1("ev_ic_type", icache_rtrn_type_o, 1'b0);
    chk("ev_dc_type", 256'(dcache_rtrn_type_o), 256'(0));
    chk("ev_addr", 256'(rtrn_inval_addr_o), 256'(12'hABC));
    chk("ev_way", 256'(rtrn_inval_way_o), 256'(2));
    chk("ev_tid", 256'(rtrn_tid_o), 256'(3));
    tick();
    chk1("ev_b_ic_vld", icache_rtrn_vld_o, 1'b0);
    chk1("ev_b_dc_vld", dcache_rtrn_vld_o, 1'b1);
    tick();
    chk1("ev_c_dc_vld", dcache_rtrn_vld_o, 1'b1);
    tick();
    chk1("ev_d_dc_vld", dcache_rtrn_vld_o, 1'b1);
    chk("ev_d_addr_hold", 256'(rtrn_inval_addr_o), 256'(12'hABC));
    dcache_rtrn_rdy_i = 1'b1;
    tick();
    chk1("ev_e_dc_vld", dcache_rtrn_vld_o, 1'b0);
    chk1("ev_e_ic_vld", icache_rtrn_vld_o, 1'b0);

    // three back-to-back ST_ACKs with both destinations stalled
    icache_rtrn_rdy_i = 1'b0;
    dcache_rtrn_rdy_i = 1'b0;
    set_pkt(4'b0100, 2'd0, '0, 1'b0, 1'b0, 12'h0, 2'd0);
    #1;
    chk1("b2b_ack0", l15_header_ack_o, 1'b1);
    tick();
    l15_threadid_i = 2'd1;
    #1;
    chk1("b2b_ack1", l15_header_ack_o, 1'b1);
    tick();
    l15_threadid_i = 2'd2;
    #1;
    chk1("b2b_ack2_full", l15_header_ack_o, 1'b0);
    chk1("b2b_head_vld", dcache_rtrn_vld_o, 1'b1);
    chk("b2b_head_type", 256'(dcache_rtrn_type_o), 256'(1));
    chk("b2b_head_tid", 256'(rtrn_tid_o), 256'(0));
    tick();
    chk1("b2b_ack_stall", l15_header_ack_o, 1'b0);
    chk("b2b_tid_hold", 256'(rtrn_tid_o), 256'(0));
    dcache_rtrn_rdy_i = 1'b1;
    #1;
    chk1("b2b_ack_pop_same_cycle", l15_header_ack_o, 1'b0);
    tick();
    chk1("b2b_ack_after_pop", l15_header_ack_o, 1'b1);
    chk("b2b_tid1", 256'(rtrn_tid_o), 256'(1));
    tick();
    l15_val_i = 1'b0;
    chk1("b2b_p2_vld", dcache_rtrn_vld_o, 1'b1);
    chk("b2b_tid2", 256'(rtrn_tid_o), 256'(2));
    tick();
    chk1("b2b_drained", dcache_rtrn_vld_o, 1'b0);

    // EVICT without targets is dropped silently; type 0101 counts an error
    set_pkt(4'b0011, 2'd0, '0, 1'b0, 1'b0, 12'h123, 2'd1);
    tick();
    l15_val_i = 1'b0;
    chk1("ev0_ic_vld", icache_rtrn_vld_o, 1'b0);
    chk1("ev0_dc_vld", dcache_rtrn_vld_o, 1'b0);
    tick();
    chk("ev0_err", 256'(err_cnt_o), 256'(0));
    set_pkt(4'b0101, 2'd0, '0, 1'b0, 1'b0, 12'h0, 2'd0);
    tick();
    l15_val_i = 1'b0;
    chk1("bad_dc_vld", dcache_rtrn_vld_o, 1'b0);
    tick();
    chk("bad_err1", 256'(err_cnt_o), 256'(1));

    // 300 unsupported packets: all accepted, counter saturates
    acks     = 0;
    vld_seen = 0;
    cyc      = 0;
    set_pkt(4'b0101, 2'd0, '0, 1'b0, 1'b0, 12'h0, 2'd0);
    while (acks < 300 && cyc < 700) begin
      #1;
      if (l15_header_ack_o) acks++;
      if (icache_rtrn_vld_o || dcache_rtrn_vld_o) vld_seen++;
      cyc++;
      tick();
    end
    l15_val_i = 1'b0;
    tick();
    tick();
    tick();
    chk("flood_acks", 256'(acks), 256'(300));
    chk("flood_cycles", 256'(cyc), 256'(300));
    chk("flood_vld", 256'(vld_seen), 256'(0));
    chk("flood_err_sat", 256'(err_cnt_o), 256'(255));

    // reset asserted while dcache is stalled on a full FIFO
    dcache_rtrn_rdy_i = 1'b0;
    set_pkt(4'b0000, 2'd1, {192'h0, 64'h1122334455667788}, 1'b0, 1'b0, 12'h0, 2'd0);
    tick();
    tick();
    #1;
    chk1("full_ack", l15_header_ack_o, 1'b0);
    chk1("full_dc_vld", dcache_rtrn_vld_o, 1'b1);
    rst_ni = 1'b0;
    #1;
    chk1("arst_dc_vld", dcache_rtrn_vld_o, 1'b0);
    chk1("arst_ack", l15_header_ack_o, 1'b0);
    chk("arst_type", 256'(dcache_rtrn_type_o), 256'(0));
    chk("arst_data", 256'(dcache_rtrn_data_o), 256'(0));
    chk("arst_err", 256'(err_cnt_o), 256'(0));
    tick();
    rst_ni    = 1'b1;
    l15_val_i = 1'b0;
    tick();
    chk1("rel_dc_vld", dcache_rtrn_vld_o, 1'b0);
    chk1("rel_ic_vld", icache_rtrn_vld_o, 1'b0);
    set_pkt(4'b0000, 2'd2, '0, 1'b0, 1'b0, 12'h0, 2'd0);
    #1;
    chk1("rel_ack", l15_header_ack_o, 1'b1);
    tick();
    l15_val_i = 1'b0;
    chk1("rel_new_vld", dcache_rtrn_vld_o, 1'b1);
    chk("rel_new_tid", 256'(rtrn_tid_o), 256'(2));
    dcache_rtrn_rdy_i = 1'b1;
    tick();
    chk1("rel_empty", dcache_rtrn_vld_o, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/wt_l15_rtrn_decoder.md
WT_L15_RTRN_DECODER -- requirements
Module: wt_l15_rtrn_decoder

Interface
REQ-001 SHALL have parameter RTRN_FIFO_DEPTH, default 2, return-packet buffer depth (power of two, >=2).
REQ-002 SHALL have parameter TID_WIDTH, default 2, transaction-ID width.
REQ-003 SHALL have parameter SWAP_ENDIAN, default 1, byte-swap each 64-bit data word when 1.
REQ-004 SHALL have port clk_i  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_ni  in  1  asynchronous active-low reset.
REQ-006 SHALL have port l15_val_i  in  1  L1.5 return packet valid.
REQ-007 SHALL have port l15_header_ack_o  out  1  packet consumed this cycle.
REQ-008 SHALL have port l15_returntype_i  in  4  L1.5 return type (LOAD_RET 0000, IFILL_RET 0001, EVICT_REQ 0011, ST_ACK 0100, INT_RET 0111, ATOMIC_RES 1110).
REQ-009 SHALL have port l15_threadid_i  in  TID_WIDTH  transaction ID.
REQ-010 SHALL have port l15_data_i  in  256  data words 0..3, word k at [64k+:64].
REQ-011 SHALL have ports l15_inval_icache_i / l15_inval_dcache_i  in  1 each  eviction targets.
REQ-012 SHALL have port l15_inval_addr_i  in  12  invalidation address bits [15:4].
REQ-013 SHALL have port l15_inval_way_i  in  2  invalidation way.
REQ-014 SHALL have ports icache_rtrn_vld_o out 1, icache_rtrn_rdy_i in 1, icache_rtrn_type_o out 1 (INV_REQ 0, IFILL_ACK 1), icache_rtrn_data_o out 256.
REQ-015 SHALL have ports dcache_rtrn_vld_o out 1, dcache_rtrn_rdy_i in 1, dcache_rtrn_type_o out 3 (INV_REQ 0, STORE_ACK 1, LOAD_ACK 2, ATOMIC_ACK 3, INT_ACK 4), dcache_rtrn_data_o out 128.
REQ-016 SHALL have shared outputs rtrn_tid_o (TID_WIDTH), rtrn_inval_addr_o (12), rtrn_inval_way_o (2), valid with either vld.
REQ-017 SHALL have port err_cnt_o  out  8  saturating count of dropped unsupported packets.

Function
REQ-018 SHALL assert l15_header_ack_o = l15_val_i AND FIFO not full, combinationally; packet captured into FIFO on that edge.
REQ-019 SHALL block capture when full even if a pop occurs the same cycle.
REQ-020 SHALL present a captured packet at outputs no earlier than the cycle after capture; empty FIFO -> both vld low.
REQ-021 SHALL map head type: LOAD_RET->dcache LOAD_ACK; ATOMIC_RES->dcache ATOMIC_ACK; ST_ACK->dcache STORE_ACK; INT_RET->dcache INT_ACK; IFILL_RET->icache IFILL_ACK; EVICT_REQ->INV_REQ to icache if inval_icache, to dcache if inval_dcache.
REQ-022 SHALL pop any other type (or EVICT_REQ with neither flag) one cycle after reaching head, drive no vld, and increment err_cnt_o only for non-EVICT types, saturating at 255.
REQ-023 SHALL keep per-destination done flags: state IDLE (empty) -> SEND (head valid); a destination whose vld&rdy handshake completes sets its done flag and drops its vld next cycle.
REQ-024 SHALL pop the head in the cycle the last required destination handshakes (both may complete in same cycle), clear done flags, and show the next entry the following cycle (1 packet/cycle max).
REQ-025 SHALL hold all output fields stable while vld high and rdy low.
REQ-026 SHALL form dcache data as {w1,w0}, icache data as {w3,w2,w1,w0}, each word byte-reversed when SWAP_ENDIAN=1, unmodified when 0.
REQ-027 SHALL wrap FIFO read/write pointers modulo RTRN_FIFO_DEPTH with separate full/empty tracking.

Reset
REQ-028 SHALL on rst_ni low, independent of clock, empty FIFO, clear done flags, force state IDLE, err_cnt_o 0, all vld 0, l15_header_ack_o 0, data/type/tid/inval outputs 0.
REQ-029 SHALL discard in-flight and partially delivered packets on reset mid-operation; no vld asserts in the first cycle after release.

Verification
REQ-030 SHALL cover: LOAD_RET tid 1, w0=0x0011223344556677, dcache rdy=1 -> next cycle dcache vld, type 2, data[63:0]=0x7766554433221100, tid 1.
REQ-031 SHALL cover: EVICT_REQ both flags, addr 0xABC, way 2, icache rdy=1, dcache rdy=0 for 3 cycles -> icache vld 1 cycle, dcache vld 4 cycles, pop on dcache handshake.
REQ-032 SHALL cover: 3 back-to-back packets, both rdy=0 -> header_ack high for 2, low for third until first pop.
REQ-033 SHALL cover: 300 packets of type 0101 -> all acked, no vld, err_cnt_o=255.
REQ-034 SHALL cover: rst_ni low while dcache vld stalled with FIFO full -> vld 0 immediately, header_ack 0, FIFO empty after release.
